// File: rtl/sine_pkg.sv
// Constants shared by the sine sample path (sine_lut, sine_pwm_dac).
package sine_pkg;
  localparam int SAMPLE_W   = 8;
  localparam int POS_W      = 4;
  localparam int PWM_PERIOD = 2 ** SAMPLE_W;

  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one tick every PRESCALE enabled cycles; held at phase 0 while disabled.
module pwm_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  assign tick_o = en_i && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (!en_i || tick_o) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
endmodule

// File: rtl/sine_pwm_dac.sv
// Sample-to-PWM converter: one-entry pending buffer feeding a duty register
// that is reloaded only at PWM period boundaries.
module sine_pwm_dac #(
  parameter int SAMPLE_W = sine_pkg::SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                clear_underrun,
  output logic                pwm_out,
  output logic                period_start,
  output logic                underrun
);
  localparam logic [SAMPLE_W-1:0] CNT_LAST = '1;

  logic                tick;
  logic                boundary;
  logic                accept;

  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic [SAMPLE_W-1:0] pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic                underrun_q, underrun_d;
  logic                pwm_q, pwm_d;
  logic                period_start_q, period_start_d;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .tick_o (tick)
  );

  assign sample_ready = !pending_full_q;
  assign accept       = sample_valid && !pending_full_q;
  assign boundary     = tick && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d          = cnt_q;
    duty_d         = duty_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    underrun_d     = underrun_q;
    pwm_d          = en && (cnt_q < duty_q);
    period_start_d = boundary;

    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + SAMPLE_W'(1);
    end

    // An accept can only happen with the buffer empty, so it never races a load.
    if (boundary && pending_full_q) begin
      duty_d         = pending_q;
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_d      = sample_in;
      pending_full_d = 1'b1;
    end

    if (boundary && !pending_full_q) begin
      underrun_d = 1'b1;
    end else if (clear_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      underrun_q     <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      underrun_q     <= underrun_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;
endmodule

// File: tb/tb_sine_pwm_dac.sv
// Two DUTs (PRESCALE 1 and 4) on shared stimulus, checked every cycle against
// a time-based model plus literal pins for period lengths and high counts.
module tb_sine_pwm_dac;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       clear_underrun = 1'b0;

  logic [1:0] ready_w, pwm_w, ps_w, und_w;

  int n_cmp = 0;
  int n_bad = 0;

  // model state, index 0: PRESCALE=1, index 1: PRESCALE=4
  int en_cyc [2];
  int duty   [2];
  int pend_d [2];
  bit pend_v [2];
  bit und    [2];
  bit exp_pwm[2];
  bit exp_ps [2];

  always #5 clk = ~clk;

  sine_pwm_dac #(.SAMPLE_W(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(ready_w[0]),
    .clear_underrun(clear_underrun), .pwm_out(pwm_w[0]),
    .period_start(ps_w[0]), .underrun(und_w[0])
  );

  sine_pwm_dac #(.SAMPLE_W(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(ready_w[1]),
    .clear_underrun(clear_underrun), .pwm_out(pwm_w[1]),
    .period_start(ps_w[1]), .underrun(und_w[1])
  );

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      en_cyc[i] = 0; duty[i] = 0; pend_d[i] = 0; pend_v[i] = 0;
      und[i] = 0; exp_pwm[i] = 0; exp_ps[i] = 0;
    end
  endtask

  // Position within the period follows from how long en has been held high.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int p, per, pos;
      bit last, had;
      p   = (i == 0) ? 1 : 4;
      per = p * 256;
      pos  = en ? (en_cyc[i] / p) % 256 : 0;
      last = en && ((en_cyc[i] % per) == per - 1);
      had  = pend_v[i];
      exp_pwm[i] = en && (pos < duty[i]);
      exp_ps[i]  = last;
      if (last && had) begin
        duty[i] = pend_d[i];
        pend_v[i] = 0;
      end
      if (last && !had) und[i] = 1;
      else if (clear_underrun) und[i] = 0;
      if (sample_valid && !had) begin
        pend_v[i] = 1;
        pend_d[i] = sample_in;
      end
      en_cyc[i] = en ? en_cyc[i] + 1 : 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pwm_out[%0d]", i), pwm_w[i], exp_pwm[i]);
      chk($sformatf("period_start[%0d]", i), ps_w[i], exp_ps[i]);
      chk($sformatf("sample_ready[%0d]", i), ready_w[i], !pend_v[i]);
      chk($sformatf("underrun[%0d]", i), und_w[i], und[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [7:0] d);
    sample_in = d;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_ps(input int idx, input int budget, output int steps, output int hi);
    steps = 0;
    hi = 0;
    while (ps_w[idx] !== 1'b1 && steps < budget) begin
      step();
      steps++;
      hi += int'(pwm_w[idx]);
    end
    if (ps_w[idx] !== 1'b1) chk($sformatf("wait_ps_timeout[%0d]", idx), 0, 1);
  endtask

  task automatic measure(input int idx, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step();
      hi += int'(pwm_w[idx]);
    end
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_pwm[%0d]", i), pwm_w[i], 0);
      chk($sformatf("rst_ready[%0d]", i), ready_w[i], 1);
      chk($sformatf("rst_underrun[%0d]", i), und_w[i], 0);
    end
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int steps, hi, hi2;
    model_reset();
    step();
    step();
    rst = 1'b0;
    chk("reset_ready", ready_w[0], 1);

    // prescale 4: 1024-cycle periods, duty 0x80 -> 512 high
    en = 1'b1;
    push(8'h80);
    wait_ps(1, 1100, steps, hi);
    chk("p4_first_len", steps + 1, 1024);
    chk("p4_first_hi", hi, 0);
    measure(1, 1024, hi);
    chk("p4_hi_0x80", hi, 512);
    measure(1, 300, hi);
    en = 1'b0;
    step();
    chk("p4_en_drop_pwm", pwm_w[1], 0);
    measure(1, 5, hi);
    en = 1'b1;
    wait_ps(1, 1100, steps, hi);
    chk("p4_reenable_len", steps, 1024);
    chk("p4_reenable_hi", hi, 512);

    // reset mid-run with duty 0x80 and a pending sample
    push(8'h80);
    chk("pre_rst_pending", ready_w[0], 0);
    @(negedge clk);
    model_edge();
    compare_all();
    reset_now();
    wait_ps(0, 300, steps, hi);
    chk("post_rst_first_hi", hi, 0);

    // basic PWM at prescale 1
    en = 1'b0;
    reset_now();
    en = 1'b1;
    push(8'h40);
    wait_ps(0, 300, steps, hi);
    chk("basic_first_len", steps + 1, 256);
    chk("basic_first_hi", hi + int'(pwm_w[0]), hi);
    measure(0, 256, hi);
    chk("basic_hi_0x40", hi, 64);
    chk("basic_underrun", und_w[0], 1);

    // extremes
    push(8'hFF);
    wait_ps(0, 300, steps, hi);
    measure(0, 256, hi);
    chk("duty_ff_hi", hi, 255);
    push(8'h00);
    wait_ps(0, 300, steps, hi);
    measure(0, 768, hi);
    chk("duty_00_hi", hi, 0);

    // backpressure: 0x10 then 0x20 with valid held
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    chk("bp_cleared", und_w[0], 0);
    sample_in = 8'h10;
    sample_valid = 1'b1;
    step();
    chk("bp_ready_low", ready_w[0], 0);
    sample_in = 8'h20;
    wait_ps(0, 300, steps, hi);
    step();
    chk("bp_second_accepted", ready_w[0], 0);
    sample_valid = 1'b0;
    hi = int'(pwm_w[0]);
    measure(0, 255, hi2);
    chk("bp_hi_0x10", hi + hi2, 16);
    wait_ps(0, 300, steps, hi);
    chk("bp_underrun_zero", und_w[0], 0);
    measure(0, 256, hi);
    chk("bp_hi_0x20", hi, 32);

    // underrun set beats clear in the boundary cycle
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    measure(0, 254, hi);
    clear_underrun = 1'b1;
    step();
    chk("ur_boundary_ps", ps_w[0], 1);
    chk("ur_set_wins", und_w[0], 1);
    step();
    clear_underrun = 1'b0;
    chk("ur_cleared", und_w[0], 0);
    measure(0, 256, hi);
    chk("ur_duty_held", hi, 32);

    // randomized run
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 499) == 0) en = ~en;
      sample_valid   = ($urandom_range(0, 7) == 0);
      sample_in      = 8'($urandom);
      clear_underrun = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sine_pwm_dac.md
Name: sine_pwm_dac

Overview:
- Downstream consumer of the sine_lut output. Converts each 8-bit sine sample into a fixed-frequency PWM waveform on one pin.
- An upstream position sequencer feeds samples through a valid/ready handshake. A one-entry pending buffer decouples sample arrival from the PWM period boundary.
- Sits between the sine sample path and a uo_out bit of the top-level wrapper. An external RC filter reconstructs the analogue sine.

Parameters:
- SAMPLE_W, 8, sample and duty width; PWM period is 2**SAMPLE_W counts.
- PRESCALE, 1, clock cycles per PWM count; legal range 1..256.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable for the PWM counter and output.
- sample_in  in  SAMPLE_W  sample from sine_lut.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  pending buffer can accept a sample.
- clear_underrun  in  1  synchronous clear of the underrun flag.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-cycle strobe when a new period begins (duty load point).
- underrun  out  1  sticky flag: a period boundary found no pending sample.

Behaviour:
- Reset (async, immediate) sets: cnt=0, presc=0, duty=0, pending=0, pending_full=0, underrun=0, pwm_out=0, period_start=0. sample_ready therefore reads 1.
- sample_ready = !pending_full (combinational from the flop).
- Accept when sample_valid && sample_ready: pending <= sample_in, pending_full <= 1.
- sample_in is ignored while sample_ready=0; the upstream stage must hold it.
- Tick:
  - tick = en && (presc == PRESCALE-1).
  - While en=1, presc increments each cycle and wraps to 0 on tick.
  - cnt increments on tick, wrapping from 2**SAMPLE_W-1 to 0.
- Boundary = tick && cnt == 2**SAMPLE_W-1. At a boundary:
  - If pending_full: duty <= pending, pending_full <= 0.
  - Otherwise duty is held and underrun <= 1.
  - period_start is registered and asserted in the cycle after the boundary, i.e. the first cycle with cnt=0 and the new duty.
- Accept and boundary in the same cycle:
  - With pending_full=1: the boundary consumes the old pending. The accept cannot occur, because ready=0.
  - With pending_full=0: the new sample goes to pending, not duty, and underrun is set.
- Underrun priority: set beats clear_underrun in the same cycle.
- PWM output:
  - pwm_out <= en && (cnt < duty). One-cycle latency from cnt/duty to pin.
  - Duty 0 gives constant low; duty 255 gives 255/256 high.
- en=0:
  - presc and cnt are forced to 0, pwm_out goes 0 on the next edge, and there are no boundaries or strobes.
  - duty, pending and the handshake are unaffected.
  - When en rises, a full period runs with the current duty before the next load.
- Reset mid-period: all state clears immediately. Any in-flight pending sample is discarded.

Decomposition:
- Shared package sine_pkg holds:
  - SAMPLE_W=8 and POS_W=4 (shared with sine_lut).
  - PWM_PERIOD = 2**SAMPLE_W.
- Optional sub-module pwm_tick_gen (prescaler: en, PRESCALE → tick) for reuse by other timed stages.
- The rest stays flat: double buffer, counter, compare.

Test Plan:
- Reset check: assert rst mid-run with en=1, duty=0x80, pending_full=1 → in the same cycle pwm_out=0, sample_ready=1, underrun=0; after release, first period all low (duty=0).
- Basic PWM (PRESCALE=1): push 0x40, en=1 → first 256 cycles low; period_start one cycle after the boundary; then exactly 64 cycles high and 192 low per period; underrun=1 from the second boundary, since no new sample.
- Extremes: duty 0x00 → pwm_out never high over 3 periods; duty 0xFF → 255 high, 1 low per period.
- Backpressure: offer 0x10 then 0x20 back-to-back with valid held → 0x10 accepted; ready=0 until the boundary; 0x20 accepted the cycle after; duties load 0x10 then 0x20 on consecutive periods; underrun stays 0.
- Underrun priority: let a boundary pass with no pending while clear_underrun=1 that cycle → underrun=1; clear next cycle → 0; duty unchanged.
- Prescale: PRESCALE=4, duty 0x80 → period 1024 cycles, 512 high; drop en mid-period → pwm_out=0 the next cycle; re-enable → new full 1024-cycle period.
